// File: rtl/mips_io_pkg.sv
// ============================================================================
// Module      : mips_io_pkg
// Description : Shared constants and types for the mips_led_io peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_io_pkg;

    localparam logic [2:0] ADDR_LED_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK   = 3'd1;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_CYCLE_CNT    = 3'd3;
    localparam logic [2:0] ADDR_PWM_DUTY     = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/mips_led_io_if.sv
// ============================================================================
// Module      : mips_led_io_if
// Description : CPU data-memory bus between the pipeline and the LED block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_led_io_if;
    logic        req;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

`default_nettype wire

// File: rtl/mips_led_blink.sv
// ============================================================================
// Module      : mips_led_blink
// Description : Blink period counter; phase toggles every period+1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_led_blink #(
    parameter int BLINK_W = 24
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [BLINK_W-1:0] period,
    input  wire logic               period_wr,
    output logic                    phase
);

    logic [BLINK_W-1:0] cnt_q, cnt_d;
    logic               phase_q, phase_d;

    // A zero period parks the blinker; a period write restarts it cleanly.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr || (period == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/mips_led_io.sv
// ============================================================================
// Module      : mips_led_io
// Description : Memory-mapped LED peripheral (steady, blink, optional PWM).
//               Define MIPS_LED_IO_PWM_EN to add the PWM dimmer at addr 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_led_io
    import mips_io_pkg::*;
#(
    parameter int         WAIT_STATES = 0,
    parameter int         BLINK_W     = 24,
    parameter logic [7:0] RESET_LED   = 8'h00
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mips_led_io_if.slave    bus,
    output logic [7:0]      led
);

    localparam bit         c_HAS_WAIT  = (WAIT_STATES > 0);
    localparam int         c_WAIT_M1   = c_HAS_WAIT ? (WAIT_STATES - 1) : 0;
    localparam logic [2:0] c_WAIT_LOAD = c_WAIT_M1[2:0];

    bus_state_e         state_q, state_d;
    logic [2:0]         wait_cnt_q, wait_cnt_d;
    logic               we_q, we_d;
    logic [2:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ack_q, ack_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [7:0]         led_data_q, led_data_d;
    logic [7:0]         blink_mask_q, blink_mask_d;
    logic [BLINK_W-1:0] blink_period_q, blink_period_d;
    logic [31:0]        cycle_cnt_q, cycle_cnt_d;
    logic [7:0]         led_q, led_d;

    logic               w_wr_en;
    logic               w_period_wr;
    logic               w_phase;
    logic [31:0]        w_rd_mux;
    logic               w_unused_wdata;

`ifdef MIPS_LED_IO_PWM_EN
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [7:0]         pwm_duty_q, pwm_duty_d;
    logic               w_pwm_on;
`endif

    // Bus FSM: the register write and ack share the edge that leaves RESP.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ack_d      = 1'b0;
        rdata_d    = '0;
        w_wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (c_HAS_WAIT) begin
                        state_d    = WAIT;
                        wait_cnt_d = c_WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 3'd0) state_d = RESP;
                else                    wait_cnt_d = wait_cnt_q - 3'd1;
            end
            RESP: begin
                ack_d   = 1'b1;
                rdata_d = w_rd_mux;
                w_wr_en = we_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = '0;
        case (addr_q)
            ADDR_LED_DATA:     w_rd_mux = {24'd0, led_data_q};
            ADDR_BLINK_MASK:   w_rd_mux = {24'd0, blink_mask_q};
            ADDR_BLINK_PERIOD: w_rd_mux = 32'(blink_period_q);
            ADDR_CYCLE_CNT:    w_rd_mux = cycle_cnt_q;
`ifdef MIPS_LED_IO_PWM_EN
            ADDR_PWM_DUTY:     w_rd_mux = {24'd0, pwm_duty_q};
`endif
            default:           w_rd_mux = '0;
        endcase
    end

    assign w_period_wr = w_wr_en && (addr_q == ADDR_BLINK_PERIOD);
    // Store data wider than the widest register is intentionally dropped.
    assign w_unused_wdata = ^wdata_q;

    always_comb begin
        led_data_d     = led_data_q;
        blink_mask_d   = blink_mask_q;
        blink_period_d = blink_period_q;
        cycle_cnt_d    = cycle_cnt_q + 32'd1;
        if (w_wr_en && (addr_q == ADDR_LED_DATA))   led_data_d   = wdata_q[7:0];
        if (w_wr_en && (addr_q == ADDR_BLINK_MASK)) blink_mask_d = wdata_q[7:0];
        if (w_period_wr)                            blink_period_d = wdata_q[BLINK_W-1:0];
    end

`ifdef MIPS_LED_IO_PWM_EN
    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + 8'd1;
        pwm_duty_d = pwm_duty_q;
        if (w_wr_en && (addr_q == ADDR_PWM_DUTY)) pwm_duty_d = wdata_q[7:0];
    end

    assign w_pwm_on = (pwm_cnt_q < pwm_duty_q) || (pwm_duty_q == 8'hFF);
    assign led_d    = (led_data_q & ~(blink_mask_q & {8{w_phase}})) & {8{w_pwm_on}};
`else
    assign led_d    = led_data_q & ~(blink_mask_q & {8{w_phase}});
`endif

    mips_led_blink #(
        .BLINK_W   (BLINK_W)
    ) u_blink (
        .clk       (clk),
        .rst       (rst),
        .period    (blink_period_q),
        .period_wr (w_period_wr),
        .phase     (w_phase)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            ack_q          <= 1'b0;
            rdata_q        <= '0;
            led_data_q     <= RESET_LED;
            blink_mask_q   <= '0;
            blink_period_q <= '0;
            cycle_cnt_q    <= '0;
            led_q          <= RESET_LED;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            ack_q          <= ack_d;
            rdata_q        <= rdata_d;
            led_data_q     <= led_data_d;
            blink_mask_q   <= blink_mask_d;
            blink_period_q <= blink_period_d;
            cycle_cnt_q    <= cycle_cnt_d;
            led_q          <= led_d;
        end
    end

`ifdef MIPS_LED_IO_PWM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_q  <= '0;
            pwm_duty_q <= 8'hFF;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            pwm_duty_q <= pwm_duty_d;
        end
    end
`endif

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign led       = led_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_led_io.sv
// ============================================================================
// Module      : tb_mips_led_io
// Description : Scoreboard bench for mips_led_io (zero and three wait states).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_led_io;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst3;
    logic [7:0] led0, led3;

    mips_led_io_if bus0 ();
    mips_led_io_if bus3 ();

    mips_led_io #(.WAIT_STATES(0), .BLINK_W(24), .RESET_LED(8'h00)) u_dut0 (
        .clk(clk), .rst(rst0), .bus(bus0.slave), .led(led0));
    mips_led_io #(.WAIT_STATES(3), .BLINK_W(24), .RESET_LED(8'h00)) u_dut3 (
        .clk(clk), .rst(rst3), .bus(bus3.slave), .led(led3));

    logic        m_req   [2];
    logic        m_we    [2];
    logic [2:0]  m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        s_ack   [2];
    logic [31:0] s_rdata [2];

    assign bus0.req   = m_req[0];
    assign bus0.we    = m_we[0];
    assign bus0.addr  = m_addr[0];
    assign bus0.wdata = m_wdata[0];
    assign bus3.req   = m_req[1];
    assign bus3.we    = m_we[1];
    assign bus3.addr  = m_addr[1];
    assign bus3.wdata = m_wdata[1];
    assign s_ack[0]   = bus0.ack;
    assign s_rdata[0] = bus0.rdata;
    assign s_ack[1]   = bus3.ack;
    assign s_rdata[1] = bus3.rdata;

    typedef struct {
        logic [31:0] rdata;
        bit          chk_rd;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // idx 0 = zero-wait DUT, idx 1 = three-wait DUT.
    task automatic xfer(input string tag, input int idx, input logic we, input logic [2:0] addr,
                        input logic [31:0] wdata, input bit chk_rd, input logic [31:0] exp_rd,
                        input int exp_lat, input bit keep_req, output logic [31:0] rd);
        exp_t e;
        int   lat;
        bit   got;
        e.rdata = exp_rd; e.chk_rd = chk_rd; e.lat = exp_lat;
        sb_q.push_back(e);
        m_req[idx] = 1'b1; m_we[idx] = we; m_addr[idx] = addr; m_wdata[idx] = wdata;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (s_ack[idx]) got = 1'b1;
        end
        rd = s_rdata[idx];
        if (!keep_req) m_req[idx] = 1'b0;
        e = sb_q.pop_front();
        if (!got) check({tag, " ack_timeout"}, 32'(got), 32'd1);
        else begin
            check({tag, " latency"}, 32'(lat), 32'(e.lat));
            if (e.chk_rd) check({tag, " rdata"}, rd, e.rdata);
            if (!keep_req) begin
                tick();
                check({tag, " ack_after"}, 32'(s_ack[idx]), 32'd0);
                check({tag, " rdata_after"}, s_rdata[idx], 32'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd1, rd2;
        int          polls, miss, on_cnt, seen_ack;
        for (int i = 0; i < 2; i++) begin
            m_req[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
        end
        rst0 = 1'b0; rst3 = 1'b0;
        #100;
        rst0 = 1'b1; rst3 = 1'b1;
        tick();
        check("reset led", 32'(led0), 32'h00);
        check("reset ack", 32'(s_ack[0]), 32'd0);
        check("reset rdata", s_rdata[0], 32'd0);
        check("reset led3", 32'(led3), 32'h00);

        // Cycle counter: read after 10 cycles, then re-read 3 cycles later.
        repeat (10) tick();
        xfer("cnt1", 0, 1'b0, 3'd3, '0, 1'b0, '0, 2, 1'b0, rd1);
        check("cnt range", 32'(rd1 >= 32'd10 && rd1 <= 32'd12), 32'd1);
        xfer("cnt2", 0, 1'b0, 3'd3, '0, 1'b0, '0, 2, 1'b0, rd2);
        check("cnt step", rd2, rd1 + 32'd3);

        // Store then load, zero wait states.
        xfer("st led", 0, 1'b1, 3'd0, 32'h0000_00A5, 1'b0, '0, 2, 1'b0, rd);
        check("led A5", 32'(led0), 32'hA5);
        xfer("ld led", 0, 1'b0, 3'd0, '0, 1'b1, 32'h0000_00A5, 2, 1'b0, rd);

        // Three wait states, with back-to-back requests.
        xfer("ws3 ld0", 1, 1'b0, 3'd0, '0, 1'b1, 32'h0, 5, 1'b1, rd);
        xfer("ws3 b2b", 1, 1'b0, 3'd0, '0, 1'b1, 32'h0, 5, 1'b0, rd);
        xfer("ws3 st mask", 1, 1'b1, 3'd1, 32'h0000_003C, 1'b0, '0, 5, 1'b0, rd);
        xfer("ws3 ld mask", 1, 1'b0, 3'd1, '0, 1'b1, 32'h0000_003C, 5, 1'b0, rd);
        xfer("ws3 st per", 1, 1'b1, 3'd2, 32'hFFFF_FFFF, 1'b0, '0, 5, 1'b0, rd);
        xfer("ws3 ld per", 1, 1'b0, 3'd2, '0, 1'b1, 32'h00FF_FFFF, 5, 1'b0, rd);
        xfer("ws3 per0", 1, 1'b1, 3'd2, 32'h0, 1'b0, '0, 5, 1'b0, rd);

        // Blink: half-period of five cycles.
        xfer("st ff", 0, 1'b1, 3'd0, 32'h0000_00FF, 1'b0, '0, 2, 1'b0, rd);
        xfer("st mask", 0, 1'b1, 3'd1, 32'h0000_000F, 1'b0, '0, 2, 1'b0, rd);
        xfer("st per4", 0, 1'b1, 3'd2, 32'd4, 1'b0, '0, 2, 1'b0, rd);
        polls = 0;
        while (led0 !== 8'hF0 && polls < 20) begin
            tick();
            polls++;
        end
        check("blink first", 32'(polls), 32'd5);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("blink seq %0d", i), 32'(led0), ((i / 5) % 2 == 0) ? 32'hF0 : 32'hFF);
            tick();
        end
        xfer("st per0", 0, 1'b1, 3'd2, 32'd0, 1'b0, '0, 2, 1'b0, rd);
        miss = 0;
        for (int i = 0; i < 12; i++) begin
            if (led0 !== 8'hFF) miss++;
            tick();
        end
        check("blink off steady", 32'(miss), 32'd0);

        // Read-only and unmapped addresses.
        xfer("st cnt", 0, 1'b1, 3'd3, 32'd0, 1'b0, '0, 2, 1'b0, rd);
        xfer("ld cnt a", 0, 1'b0, 3'd3, '0, 1'b0, '0, 2, 1'b0, rd1);
        check("cnt not cleared", 32'(rd1 > 32'd100), 32'd1);
        xfer("ld cnt b", 0, 1'b0, 3'd3, '0, 1'b0, '0, 2, 1'b0, rd2);
        check("cnt step2", rd2, rd1 + 32'd3);
        xfer("st a7", 0, 1'b1, 3'd7, 32'hFFFF_FFFF, 1'b0, '0, 2, 1'b0, rd);
        xfer("ld a7", 0, 1'b0, 3'd7, '0, 1'b1, 32'h0, 2, 1'b0, rd);
        xfer("st a5", 0, 1'b1, 3'd5, 32'h0000_0012, 1'b0, '0, 2, 1'b0, rd);
        xfer("ld led ff", 0, 1'b0, 3'd0, '0, 1'b1, 32'h0000_00FF, 2, 1'b0, rd);

`ifdef MIPS_LED_IO_PWM_EN
        xfer("ld duty rst", 0, 1'b0, 3'd4, '0, 1'b1, 32'h0000_00FF, 2, 1'b0, rd);
        xfer("st duty", 0, 1'b1, 3'd4, 32'h0000_0040, 1'b0, '0, 2, 1'b0, rd);
        xfer("ld duty", 0, 1'b0, 3'd4, '0, 1'b1, 32'h0000_0040, 2, 1'b0, rd);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (led0 === 8'hFF) on_cnt++;
            tick();
        end
        check("pwm on cycles", 32'(on_cnt), 32'd64);
        xfer("st duty0", 0, 1'b1, 3'd4, 32'h0, 1'b0, '0, 2, 1'b0, rd);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (led0 !== 8'h00) on_cnt++;
            tick();
        end
        check("pwm duty0 off", 32'(on_cnt), 32'd0);
`else
        xfer("st a4", 0, 1'b1, 3'd4, 32'h0000_0040, 1'b0, '0, 2, 1'b0, rd);
        xfer("ld a4", 0, 1'b0, 3'd4, '0, 1'b1, 32'h0, 2, 1'b0, rd);
        check("led after a4", 32'(led0), 32'hFF);
`endif

        // Reset in the middle of a wait-state transaction.
        xfer("ws3 st 5a", 1, 1'b1, 3'd0, 32'h0000_005A, 1'b0, '0, 5, 1'b0, rd);
        check("ws3 led 5a", 32'(led3), 32'h5A);
        seen_ack = 0;
        m_req[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 3'd0;
        tick();
        if (s_ack[1]) seen_ack++;
        tick();
        if (s_ack[1]) seen_ack++;
        rst3 = 1'b0;
        #1;
        check("rst ack", 32'(s_ack[1]), 32'd0);
        check("rst led", 32'(led3), 32'h00);
        tick();
        tick();
        m_req[1] = 1'b0;
        rst3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_ack[1]) seen_ack++;
        end
        check("aborted no ack", 32'(seen_ack), 32'd0);
        check("rst led after", 32'(led3), 32'h00);
        xfer("post rst ld", 1, 1'b0, 3'd0, '0, 1'b1, 32'h0, 5, 1'b0, rd);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
